uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares the single UART transmitter between up to N_REQ byte producers (e.g. the Nios bridge, the `control_uart` reply path, the `uart_rx` loopback). It selects one requester, hands its byte to the transmitter with a one-cycle start pulse, and tracks the transmitter's busy flag until the frame completes. It optionally keeps the grant with one requester for a bounded burst. It also flags a transmitter that never acknowledges a start.

---
 rtl/uart_tx_arbiter.sv | 154 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ byte producers,
// with bounded burst retention and a sticky timeout flag for a silent transmitter.
module uart_tx_arbiter #(
    parameter int N_REQ        = 4,
    parameter int DATA_W       = 8,
    parameter int MAX_BURST    = 4,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*DATA_W-1:0]    req_data,
    output logic [N_REQ-1:0]           ack,
    output logic [DATA_W-1:0]          tx_data,
    output logic                       tx_start,
    input  logic                       tx_busy,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       active,
    output logic                       err_timeout,
    output logic [$clog2(N_REQ)-1:0]   err_id,
    input  logic                       err_clr
);

    localparam int ID_W = $clog2(N_REQ);
    localparam int BC_W = $clog2(MAX_BURST + 1);
    localparam int TO_W = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic                tx_start_q, tx_start_d;
    logic [N_REQ-1:0]    ack_q, ack_d;
    logic [ID_W-1:0]     grant_id_q, grant_id_d;
    logic [BC_W-1:0]     burst_cnt_q, burst_cnt_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic                err_timeout_q, err_timeout_d;
    logic [ID_W-1:0]     err_id_q, err_id_d;

    logic [ID_W-1:0]     sel_idx;
    logic                sel_keep;
    logic                sel_found;
    logic [ID_W-1:0]     cand;

    // Winner selection: keep the current owner while its burst lasts, otherwise
    // rotate starting just after it; the owner itself is the last candidate.
    always_comb begin
        sel_idx   = grant_id_q;
        sel_keep  = 1'b0;
        sel_found = 1'b0;
        cand      = grant_id_q;
        if (req[grant_id_q] && (burst_cnt_q < BC_W'(MAX_BURST))) begin
            sel_keep  = 1'b1;
            sel_found = 1'b1;
        end else begin
            for (int k = 1; k <= N_REQ; k++) begin
                cand = ID_W'((int'(grant_id_q) + k) % N_REQ);
                if (!sel_found && req[cand]) begin
                    sel_idx   = cand;
                    sel_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        tx_data_d     = tx_data_q;
        tx_start_d    = 1'b0;
        ack_d         = '0;
        grant_id_d    = grant_id_q;
        burst_cnt_d   = burst_cnt_q;
        to_cnt_d      = to_cnt_q;
        err_timeout_d = err_timeout_q;
        err_id_d      = err_id_q;

        if (err_clr) begin
            err_timeout_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                to_cnt_d = '0;
                if (|req) begin
                    state_d     = WAIT_BUSY;
                    tx_data_d   = req_data[int'(sel_idx)*DATA_W +: DATA_W];
                    tx_start_d  = 1'b1;
                    ack_d       = N_REQ'(1) << sel_idx;
                    grant_id_d  = sel_idx;
                    burst_cnt_d = sel_keep ? (burst_cnt_q + BC_W'(1)) : BC_W'(1);
                end
            end
            WAIT_BUSY: begin
                // The start-pulse cycle itself cannot see busy yet, hence to_cnt != 0.
                if ((to_cnt_q != '0) && tx_busy) begin
                    state_d  = WAIT_DONE;
                    to_cnt_d = '0;
                end else if (to_cnt_q == TO_W'(BUSY_TIMEOUT - 1)) begin
                    state_d       = IDLE;
                    to_cnt_d      = '0;
                    err_timeout_d = 1'b1;
                    err_id_d      = grant_id_q;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            tx_data_q     <= '0;
            tx_start_q    <= 1'b0;
            ack_q         <= '0;
            grant_id_q    <= ID_W'(N_REQ - 1);
            burst_cnt_q   <= '0;
            to_cnt_q      <= '0;
            err_timeout_q <= 1'b0;
            err_id_q      <= '0;
        end else begin
            state_q       <= state_d;
            tx_data_q     <= tx_data_d;
            tx_start_q    <= tx_start_d;
            ack_q         <= ack_d;
            grant_id_q    <= grant_id_d;
            burst_cnt_q   <= burst_cnt_d;
            to_cnt_q      <= to_cnt_d;
            err_timeout_q <= err_timeout_d;
            err_id_q      <= err_id_d;
        end
    end

    assign tx_data     = tx_data_q;
    assign tx_start    = tx_start_q;
    assign ack         = ack_q;
    assign grant_id    = grant_id_q;
    assign active      = (state_q != IDLE);
    assign err_timeout = err_timeout_q;
    assign err_id      = err_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed plus randomized bench for uart_tx_arbiter against a behavioural
// round-robin/burst model and a scripted transmitter.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;
    localparam int BT = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    ack;
    logic [DW-1:0]   tx_data;
    logic            tx_start;
    logic            tx_busy;
    logic [1:0]      grant_id;
    logic            active;
    logic            err_timeout;
    logic [1:0]      err_id;
    logic            err_clr;

    int checks = 0;
    int errors = 0;
    int m_last;
    int m_burst;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .N_REQ(N), .DATA_W(DW), .MAX_BURST(MB), .BUSY_TIMEOUT(BT)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data), .ack(ack),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .grant_id(grant_id), .active(active), .err_timeout(err_timeout),
        .err_id(err_id), .err_clr(err_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last  = N - 1;
        m_burst = 0;
    endtask

    // Owner keeps the link while requesting and under MB bytes; otherwise the
    // first requester found walking upward from the owner (owner last) wins.
    task automatic model_pick(input logic [N-1:0] r, output int g, output int nb);
        g  = -1;
        nb = 0;
        if (r[m_last] && m_burst < MB) begin
            g  = m_last;
            nb = m_burst + 1;
        end else begin
            for (int k = 1; k <= N; k++) begin
                if (g < 0 && r[(m_last + k) % N]) begin
                    g  = (m_last + k) % N;
                    nb = 1;
                end
            end
        end
    endtask

    task automatic rand_data();
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = DW'($urandom_range(0, 255));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_tx_start"}, tx_start, 0);
        chk({tag, "_ack"}, ack, 0);
        chk({tag, "_tx_data"}, tx_data, 0);
        chk({tag, "_grant_id"}, grant_id, N - 1);
        chk({tag, "_active"}, active, 0);
        chk({tag, "_err_timeout"}, err_timeout, 0);
        chk({tag, "_err_id"}, err_id, 0);
    endtask

    // One frame. dly = cycles from tx_start to busy sampled (0 = never, timeout);
    // len = busy length. nreq is applied right after the ack. g returns DUT grant_id.
    task automatic do_frame(input string tag, input int dly, input int len,
                            input logic [N-1:0] nreq, input bit clr_edge,
                            input bit rst_mid, output int g);
        int exp_g, nb, waited;
        logic [DW-1:0] exp_d;
        model_pick(req, exp_g, nb);
        if (exp_g < 0) exp_g = 0;
        exp_d  = req_data[exp_g*DW +: DW];
        waited = 0;
        while (!tx_start && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        g = int'(grant_id);
        chk({tag, "_start"}, tx_start, 1);
        if (!tx_start) return;
        chk({tag, "_grant"}, grant_id, exp_g);
        chk({tag, "_data"}, tx_data, exp_d);
        chk({tag, "_ack"}, ack, 32'(1) << exp_g);
        chk({tag, "_active"}, active, 1);
        m_last  = exp_g;
        m_burst = nb;
        req = nreq;
        rand_data();
        @(negedge clk);
        chk({tag, "_start_w"}, {tx_start, ack}, 0);
        if (dly == 0) begin
            for (int k = 2; k <= BT; k++) begin
                @(negedge clk);
                if (k == BT - 1) begin
                    chk({tag, "_to_early"}, {err_timeout, active}, 2'b01);
                    if (clr_edge) err_clr = 1'b1;
                end
                if (k == BT) begin
                    chk({tag, "_to_flag"}, err_timeout, 1);
                    chk({tag, "_to_id"}, err_id, exp_g);
                    chk({tag, "_to_idle"}, active, 0);
                    err_clr = 1'b0;
                end
            end
        end else begin
            repeat (dly - 2) @(negedge clk);
            tx_busy = 1'b1;
            if (rst_mid) begin
                repeat (2) @(negedge clk);
                reset = 1'b0;
                #1;
                chk_reset_vals({tag, "_rst"});
                tx_busy = 1'b0;
                model_reset();
                @(negedge clk);
                reset = 1'b1;
                return;
            end
            repeat (len) @(negedge clk);
            chk({tag, "_hold"}, {active, tx_data}, {1'b1, exp_d});
            tx_busy = 1'b0;
            @(negedge clk);
            chk({tag, "_done"}, active, 0);
        end
    endtask

    initial begin
        int g;
        int burst_exp[9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
        reset    = 1'b0;
        req      = '0;
        req_data = '0;
        tx_busy  = 1'b0;
        err_clr  = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        reset = 1'b1;

        repeat (4) @(negedge clk);
        chk("idle_noreq", {active, tx_start}, 0);

        // single requester, byte 0x41, busy 3 cycles after start for 20 cycles
        req = 4'b0001;
        req_data[7:0] = 8'h41;
        do_frame("single", 3, 20, 4'b0000, 0, 0, g);
        repeat (3) @(negedge clk);
        chk("single_quiet", {active, tx_start}, 0);

        // burst retention from a fresh reset
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        req = 4'b0011;
        rand_data();
        for (int i = 0; i < 9; i++) begin
            do_frame("burst", 2, 2, 4'b0011, 0, 0, g);
            chk("burst_order", g, burst_exp[i]);
        end

        req = 4'b0001;
        for (int i = 0; i < 6; i++) begin
            do_frame("solo", 2, 1, 4'b0001, 0, 0, g);
            chk("solo_order", g, 0);
        end

        req = 4'b1111;
        for (int i = 0; i < 10; i++) do_frame("all4", 3, 2, 4'b1111, 0, 0, g);

        // busy never rises
        req = 4'b0100;
        do_frame("timeout", 0, 0, 4'b1000, 0, 0, g);
        do_frame("after_to", 2, 2, 4'b0000, 0, 0, g);
        chk("sticky", err_timeout, 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("err_clr", err_timeout, 0);

        req = 4'b0010;
        do_frame("to_clr_edge", 0, 0, 4'b0000, 1, 0, g);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("err_clr2", err_timeout, 0);

        // reset in WAIT_DONE, then req=0100 must win first
        req = 4'b1000;
        do_frame("rst_mid", 2, 0, 4'b0100, 0, 1, g);
        do_frame("post_rst", 2, 2, 4'b0000, 0, 0, g);
        chk("post_rst_id", g, 2);

        req = 4'($urandom_range(1, 15));
        rand_data();
        for (int i = 0; i < 40; i++) begin
            int dly;
            dly = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(2, 6));
            do_frame("rand", dly, int'($urandom_range(1, 5)), 4'($urandom_range(1, 15)), 0, 0, g);
            if (dly == 0) begin
                err_clr = 1'b1;
                @(negedge clk);
                err_clr = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
